// File: rtl/packet_fifo.sv
// Packet FIFO: beats are stored speculatively and become visible at the output only once
// their packet's last beat is written; an abort rewinds the write pointer to the last commit.
module packet_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int CHUNK_IN  = 4,
    parameter int CHUNK_OUT = 4
) (
    input  logic             sysClk,
    input  logic             reset,
    output logic [DEPTH:0]   depth,
    output logic [DEPTH:0]   pktCount,
    input  logic [WIDTH-1:0] iData,
    input  logic             iLast,
    input  logic             iAbort,
    input  logic             iValid,
    output logic             iReady,
    output logic             iReadyChunk,
    output logic [WIDTH-1:0] oData,
    output logic             oLast,
    output logic             oValid,
    output logic             oValidChunk,
    input  logic             oReady
);
    localparam int N = 2 ** DEPTH;
    localparam logic [DEPTH:0] FULL        = {1'b1, {DEPTH{1'b0}}};
    localparam logic [DEPTH:0] CHUNK_IN_W  = (DEPTH + 1)'(CHUNK_IN);
    localparam logic [DEPTH:0] CHUNK_OUT_W = (DEPTH + 1)'(CHUNK_OUT);

    logic [DEPTH:0] wr_spec_reg;
    logic [DEPTH:0] wr_commit_reg;
    logic [DEPTH:0] rd_reg;
    logic [DEPTH:0] pkt_count_reg;
    logic [DEPTH:0] pkt_count_next;
    logic [DEPTH:0] spec_count;
    logic [DEPTH:0] free_count;
    logic [WIDTH:0] entry_q [N];

    logic write_en;
    logic commit_en;
    logic abort_en;
    logic read_en;
    logic pop_last;

    // Pointers carry one extra MSB so full and empty are distinguishable after wrap.
    assign spec_count = wr_spec_reg - rd_reg;
    assign depth      = wr_commit_reg - rd_reg;
    assign free_count = FULL - spec_count;
    assign pktCount   = pkt_count_reg;

    assign iReady      = (spec_count != FULL);
    assign iReadyChunk = (free_count >= CHUNK_IN_W);
    assign oValid      = (depth != '0);
    assign oValidChunk = (depth >= CHUNK_OUT_W);

    assign {oLast, oData} = entry_q[rd_reg[DEPTH-1:0]];

    assign write_en  = iValid && iReady && !iAbort;
    assign commit_en = write_en && iLast;
    assign abort_en  = iValid && iAbort;
    assign read_en   = oValid && oReady;
    assign pop_last  = read_en && oLast;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_entry
            logic [WIDTH:0] entry_reg;
            always_ff @(posedge sysClk) begin
                if (write_en && (wr_spec_reg[DEPTH-1:0] == DEPTH'(gi))) begin
                    entry_reg <= {iLast, iData};
                end
            end
            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    always_comb begin
        pkt_count_next = pkt_count_reg;
        case ({commit_en, pop_last})
            2'b10:   pkt_count_next = pkt_count_reg + 1'b1;
            2'b01:   pkt_count_next = pkt_count_reg - 1'b1;
            default: pkt_count_next = pkt_count_reg;
        endcase
    end

    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) begin
            wr_spec_reg   <= '0;
            wr_commit_reg <= '0;
            rd_reg        <= '0;
            pkt_count_reg <= '0;
        end else begin
            if (abort_en) begin
                wr_spec_reg <= wr_commit_reg;
            end else if (write_en) begin
                wr_spec_reg <= wr_spec_reg + 1'b1;
                if (iLast) begin
                    wr_commit_reg <= wr_spec_reg + 1'b1;
                end
            end
            if (read_en) begin
                rd_reg <= rd_reg + 1'b1;
            end
            pkt_count_reg <= pkt_count_next;
        end
    end
endmodule
